// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// The optional opcode legality check is enabled with IFU_OPCODE_CHECK_EN.
package ifu_pkg;

    localparam int OPCODE_W = 4;
    localparam int NUM_OPS  = 13;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        DRAIN = 3'd4
    } ifu_state_e;

    // Opcodes at or above NUM_OPS have no decoder output.
    function automatic logic op_is_illegal(input logic [OPCODE_W-1:0] op);
        return (op >= OPCODE_W'(NUM_OPS));
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-unit bus bundle: instruction memory port, redirect input and
// the instruction register handshake towards the opcode decoder.
interface instr_fetch_if
    import ifu_pkg::*;
#(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 16
);
    logic                      imem_req;
    logic [PC_W-1:0]           imem_addr;
    logic                      imem_gnt;
    logic                      imem_valid;
    logic [INSTR_W-1:0]        imem_rdata;
    logic                      br_valid;
    logic [PC_W-1:0]           br_target;
    logic                      ir_valid;
    logic                      ir_ready;
    logic [OPCODE_W-1:0]       opcode;
    logic [INSTR_W-OPCODE_W-1:0] operand;
    logic [PC_W-1:0]           ir_pc;
    logic                      illegal_op;

    modport master (
        output imem_req, imem_addr, ir_valid, opcode, operand, ir_pc, illegal_op,
        input  imem_gnt, imem_valid, imem_rdata, br_valid, br_target, ir_ready
    );

    modport slave (
        input  imem_req, imem_addr, ir_valid, opcode, operand, ir_pc, illegal_op,
        output imem_gnt, imem_valid, imem_rdata, br_valid, br_target, ir_ready
    );

endinterface

// File: rtl/ifu_pc.sv
// Program counter: reset load, redirect load, increment with wrap.
module ifu_pc #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic [PC_W-1:0] target_i,
    input  logic            inc_i,
    output logic [PC_W-1:0] pc_o
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    // Redirect has priority over sequential advance; all-ones wraps to 0.
    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = target_i;
        end else if (inc_i) begin
            pc_d = pc_q + PC_W'(1);
        end
    end

    // PC register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: one outstanding memory request, single
// instruction register towards the decoder, redirect from execute.
// Optional opcode legality flag: define IFU_OPCODE_CHECK_EN.
//
// state | meaning
// IDLE  | one cycle after reset, no request
// FETCH | request pc until granted
// WAIT  | granted, waiting for read data
// HOLD  | IR valid, waiting for consumer
// DRAIN | redirected while a request is in flight, discard its data
module instr_fetch
    import ifu_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter int              INSTR_W  = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    instr_fetch_if.master bus
);

    ifu_state_e          state_q;
    ifu_state_e          state_d;
    logic [PC_W-1:0]     pc;
    logic                pc_load;
    logic                pc_inc;
    logic                ir_load;
    logic                imem_req;
    logic [INSTR_W-1:0]  ir_q;
    logic [PC_W-1:0]     ir_pc_q;

    ifu_pc #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (pc_load),
        .target_i (bus.br_target),
        .inc_i    (pc_inc),
        .pc_o     (pc)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, PC control and request; a redirect always wins.
    always_comb begin
        state_d  = state_q;
        pc_load  = 1'b0;
        pc_inc   = 1'b0;
        ir_load  = 1'b0;
        imem_req = 1'b0;
        case (state_q)
            IDLE: begin
                pc_load = bus.br_valid;
                state_d = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (bus.br_valid) begin
                    pc_load = 1'b1;
                    if (bus.imem_gnt) state_d = DRAIN;
                end else if (bus.imem_gnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.br_valid) begin
                    pc_load = 1'b1;
                    state_d = bus.imem_valid ? FETCH : DRAIN;
                end else if (bus.imem_valid) begin
                    ir_load = 1'b1;
                    pc_inc  = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (bus.br_valid) begin
                    pc_load = 1'b1;
                    state_d = FETCH;
                end else if (bus.ir_ready) begin
                    state_d = FETCH;
                end
            end
            DRAIN: begin
                // Keep tracking redirects so the newest target is fetched.
                pc_load = bus.br_valid;
                if (bus.imem_valid) state_d = FETCH;
            end
            default: state_d = IDLE;
        endcase
    end

    // Instruction register and its source address.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ir_q    <= '0;
            ir_pc_q <= '0;
        end else if (ir_load) begin
            ir_q    <= bus.imem_rdata;
            ir_pc_q <= pc;
        end
    end

`ifdef IFU_OPCODE_CHECK_EN
    logic illegal_q;

    // Legality flag captured alongside the instruction register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else if (ir_load) begin
            illegal_q <= op_is_illegal(bus.imem_rdata[INSTR_W-1 -: OPCODE_W]);
        end
    end

    assign bus.illegal_op = illegal_q;
`else
    assign bus.illegal_op = 1'b0;
`endif

    assign bus.imem_req  = imem_req;
    assign bus.imem_addr = pc;
    assign bus.ir_valid  = (state_q == HOLD);
    assign bus.opcode    = ir_q[INSTR_W-1 -: OPCODE_W];
    assign bus.operand   = ir_q[INSTR_W-OPCODE_W-1:0];
    assign bus.ir_pc     = ir_pc_q;

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter PC_W, default 8, program-counter and instruction-memory address width.
REQ-002 Parameter INSTR_W, default 16, instruction word width; opcode occupies bits [INSTR_W-1:INSTR_W-4].
REQ-003 Parameter RESET_PC, default 0, PC value loaded at reset.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 imem_req  output  1  fetch request to instruction memory; held until granted.
REQ-007 imem_addr  output  PC_W  fetch address; stable while imem_req=1 and no redirect.
REQ-008 imem_gnt  input  1  memory accepts request this cycle.
REQ-009 imem_valid  input  1  read data valid, at least one cycle after grant.
REQ-010 imem_rdata  input  INSTR_W  instruction word.
REQ-011 br_valid  input  1  redirect request from execute.
REQ-012 br_target  input  PC_W  redirect address.
REQ-013 ir_valid  output  1  latched instruction available to the opcode decoder.
REQ-014 ir_ready  input  1  downstream consumes instruction this cycle.
REQ-015 opcode  output  4  instruction bits [INSTR_W-1:INSTR_W-4], feeds the 4-to-13 decoder.
REQ-016 operand  output  INSTR_W-4  remaining instruction bits.
REQ-017 ir_pc  output  PC_W  address the latched instruction came from.
REQ-018 illegal_op  output  1  latched opcode outside 0..12.

Function
REQ-019 FSM states SHALL be IDLE, FETCH, WAIT, HOLD, DRAIN.
REQ-020 IDLE: one cycle after reset release, then FETCH; imem_req=0.
REQ-021 FETCH: imem_req=1, imem_addr=pc; imem_gnt -> WAIT.
REQ-022 WAIT: imem_valid -> latch rdata into IR, ir_pc<=pc, pc<=pc+1 (modulo 2^PC_W, all-ones wraps to 0), go HOLD.
REQ-023 HOLD: ir_valid=1, IR/opcode/operand/ir_pc stable; ir_ready -> ir_valid=0 next cycle, go FETCH.
REQ-024 Minimum latency grant-to-ir_valid SHALL be 2 cycles (imem_valid one cycle after grant, ir_valid the cycle after).
REQ-025 Redirect in FETCH without grant: pc<=br_target, stay FETCH; imem_addr shows target next cycle.
REQ-026 Redirect in FETCH with imem_gnt same cycle: pc<=br_target, go DRAIN.
REQ-027 Redirect in WAIT: pc<=br_target; imem_valid same cycle -> data discarded, go FETCH; otherwise go DRAIN.
REQ-028 DRAIN: imem_req=0; imem_valid -> data discarded, go FETCH.
REQ-029 Redirect in HOLD: IR discarded, ir_valid=0 next cycle, pc<=br_target, go FETCH; redirect wins over simultaneous ir_ready.
REQ-030 Redirect in IDLE: pc<=br_target, go FETCH.
REQ-031 At most one memory request outstanding at any time.

Reset
REQ-032 rst_n=0 at a clock edge SHALL force state IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, ir_valid=0, opcode=0, operand=0, ir_pc=0, illegal_op=0, regardless of state or outstanding request.
REQ-033 A response arriving after reset release for a pre-reset request SHALL be ignored (IDLE/FETCH ignore imem_valid).

Configuration
REQ-034 Macro IFU_OPCODE_CHECK_EN defined: illegal_op registered with IR, 1 when latched opcode is 13, 14 or 15, else 0.
REQ-035 Macro undefined: illegal_op tied 0, no check logic.

Structure
REQ-036 Package ifu_pkg SHALL hold the FSM state enum, OPCODE_W=4 and NUM_OPS=13.
REQ-037 Sub-module ifu_pc SHALL implement the PC register (reset load, increment-with-wrap, redirect load).

Verification
REQ-038 Reset release, gnt immediately, valid next cycle, rdata=16'h3A5C -> imem_addr=0, ir_valid 2 cycles after grant, opcode=3, operand=12'hA5C, ir_pc=0.
REQ-039 ir_ready=0 for 5 cycles in HOLD -> ir_valid, opcode stable, imem_req=0; ir_ready=1 -> next request at addr 1.
REQ-040 pc=8'hFF, fetch completes -> ir_pc=8'hFF, next imem_addr=8'h00.
REQ-041 br_valid, br_target=8'h40 in WAIT, imem_valid 2 cycles later with 16'hFFFF -> data dropped, ir_valid never set, next imem_addr=8'h40.
REQ-042 br_valid and ir_ready same cycle in HOLD -> ir_valid=0, next imem_addr=br_target.
REQ-043 With IFU_OPCODE_CHECK_EN, rdata=16'hD000 -> illegal_op=1; rdata=16'hC000 -> illegal_op=0; without macro both 0.
